mc_ctrl_fsm: RTL
================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port OP, input, 6, IR[31:26] opcode; valid from DCD onward.
REQ-004 SHALL have port Funct, input, 6, IR[5:0] function code.
REQ-005 SHALL have port Zero, input, 1, ALU zero flag.
REQ-006 SHALL have ports PCWr, IRWr, RFWr, DMWr, outputs, 1 each, write enables.
REQ-007 SHALL have port BSel, output, 1, ALU B source: 0=register rt, 1=extended immediate.
REQ-008 SHALL have port WDSel, output, 2, RF write data: 0=ALUOut, 1=MDR, 2=PC.
REQ-009 SHALL have port NPCOp, output, 2, next PC: 0=PC+4, 1=branch target, 2=jump target, 3=rs.
REQ-010 SHALL have port EXTOp, output, 2: 0=zero-extend, 1=sign-extend, 2=shift left by 16.
REQ-011 SHALL have port ALUOp, output, 3: 0=ADDU, 1=SUBU, 2=AND, 3=OR, 4=SLT, 5=NOR, 6=SRL.
REQ-012 SHALL have port GPRSel, output, 2, write register: 0=rt, 1=rd, 2=r31.
REQ-013 SHALL have port State, output, 3, current state; Done, output, 1, instruction-complete pulse; Illegal, output, 1, undecodable-instruction pulse.

Function
REQ-014 SHALL implement states FETCH=0, DCD=1, EXE=2, MA=3, WB=4, MWB=5; codes 6 and 7 SHALL go to FETCH on next edge with all write enables 0.
REQ-015 SHALL decode opcodes: R=000000, ADDI=001000, SLTI=001010, ANDI=001100, ORI=001101, LUI=001111, LW=100011, SW=101011, BEQ=000100, BNE=000101, J=000010, JAL=000011.
REQ-016 SHALL decode R functs: ADDU=100001, SUBU=100011, AND=100100, OR=100101, NOR=100111, SLT=101010, SRL=000010, JR=001000; any other funct is illegal.
REQ-017 SHALL, in FETCH, assert IRWr=1, PCWr=1, NPCOp=0, then go to DCD.
REQ-018 SHALL, in DCD for J, assert PCWr=1, NPCOp=2, then go to FETCH.
REQ-019 SHALL, in DCD for JAL, assert PCWr=1, NPCOp=2, RFWr=1, GPRSel=2, WDSel=2, then go to FETCH; write data is the pre-jump PC, which is already PC+4.
REQ-020 SHALL, in DCD for an illegal opcode or funct, assert Illegal=1 for one cycle with no write enables and go to FETCH.
REQ-021 SHALL, in DCD for all other instructions, go to EXE.
REQ-022 SHALL, in EXE for JR, assert PCWr=1, NPCOp=3, then go to FETCH.
REQ-023 SHALL, in EXE for BEQ, assert NPCOp=1 and PCWr=Zero; for BNE, assert NPCOp=1 and PCWr=~Zero; both then go to FETCH.
REQ-024 SHALL, in EXE, go to MA for LW/SW and to WB for ALU R-type and ADDI/SLTI/ANDI/ORI/LUI.
REQ-025 SHALL, in MA for SW, assert DMWr=1 and go to FETCH; for LW, go to MWB with no writes.
REQ-026 SHALL, in MWB, assert RFWr=1, WDSel=1, GPRSel=0, then go to FETCH.
REQ-027 SHALL, in WB, assert RFWr=1, WDSel=0, and GPRSel=1 for R-type or GPRSel=0 for I-type, then go to FETCH.
REQ-028 SHALL drive ALUOp/BSel/EXTOp outside FETCH as a function of OP/Funct only, held constant through EXE/MA/WB/MWB:
- R-type: funct op, BSel=0.
- ADDI: ADDU, BSel=1, EXTOp=1.
- SLTI: SLT, BSel=1, EXTOp=1.
- ANDI: AND, BSel=1, EXTOp=0.
- ORI: OR, BSel=1, EXTOp=0.
- LUI: OR, BSel=1, EXTOp=2.
- LW/SW: ADDU, BSel=1, EXTOp=1.
- BEQ/BNE: SUBU, BSel=0, EXTOp=1.
REQ-029 SHALL drive ALUOp=0, BSel=0, EXTOp=0 in FETCH.
REQ-030 SHALL drive every write enable not explicitly asserted above to 0, and NPCOp=0 / WDSel=0 / GPRSel=0 where unspecified.
REQ-031 SHALL pulse Done=1 in the final cycle of every legal instruction (the cycle whose next state is FETCH, excluding FETCH itself and Illegal cycles).
REQ-032 SHALL use Zero only in EXE; Zero changes in other states have no effect.

Reset
REQ-033 SHALL, while rst_n=0, force State=FETCH and PCWr=IRWr=RFWr=DMWr=Done=Illegal=0 asynchronously.
REQ-034 SHALL, after deassertion mid-instruction, restart at FETCH on the first edge with rst_n=1, with no partial write retried.

Verification
REQ-035 SHALL cover ADDU (OP=000000, Funct=100001): State 0,1,2,4 -> RFWr=1 and GPRSel=1 only in WB, Done pulse, 4 cycles total.
REQ-036 SHALL cover LW: 5 cycles 0,1,2,3,5 -> MWB has RFWr=1 and WDSel=1; SW: 4 cycles -> DMWr=1 only in MA.
REQ-037 SHALL cover BEQ with Zero=1 -> PCWr=1 and NPCOp=1 in EXE; BNE with Zero=1 -> PCWr=0; 3 cycles each.
REQ-038 SHALL cover JAL -> 2 cycles, DCD with PCWr=1, RFWr=1, GPRSel=2, WDSel=2; JR -> PCWr=1 and NPCOp=3 in EXE.
REQ-039 SHALL cover OP=111111 -> Illegal=1 in DCD, no enables, State returns to 0.
REQ-040 SHALL cover rst_n=0 asserted in MA of SW -> DMWr drops to 0 immediately, and State=0 after release.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit.
// Decodes OP/Funct into an instruction class and ALU controls, then sequences
// FETCH -> DCD -> EXE -> MA/WB/MWB with per-state write enables and muxes.
module mc_ctrl_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic       BSel,
    output logic [1:0] WDSel,
    output logic [1:0] NPCOp,
    output logic [1:0] EXTOp,
    output logic [2:0] ALUOp,
    output logic [1:0] GPRSel,
    output logic [2:0] State,
    output logic       Done,
    output logic       Illegal
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        DCD   = 3'd1,
        EXE   = 3'd2,
        MA    = 3'd3,
        WB    = 3'd4,
        MWB   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_ILL,
        C_RALU,
        C_JR,
        C_IALU,
        C_LW,
        C_SW,
        C_BEQ,
        C_BNE,
        C_J,
        C_JAL
    } cls_e;

    typedef enum logic [2:0] {
        ALU_ADDU = 3'd0,
        ALU_SUBU = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_SLT  = 3'd4,
        ALU_NOR  = 3'd5,
        ALU_SRL  = 3'd6
    } alu_e;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'd0,
        EXT_SIGN = 2'd1,
        EXT_LUI  = 2'd2
    } ext_e;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_RS  = 2'd3
    } npc_e;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_MDR = 2'd1,
        WD_PC  = 2'd2
    } wd_e;

    typedef enum logic [1:0] {
        GPR_RT = 2'd0,
        GPR_RD = 2'd1,
        GPR_31 = 2'd2
    } gpr_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    state_e state_q, state_d;

    cls_e   cls;
    alu_e   dec_alu;
    logic   dec_bsel;
    ext_e   dec_ext;

    logic   pcwr, irwr, rfwr, dmwr, done, illegal;
    npc_e   npc;
    wd_e    wdsel;
    gpr_e   gprsel;

    // Instruction decode: class plus ALU/B-source/extender controls from OP/Funct.
    always_comb begin
        cls      = C_ILL;
        dec_alu  = ALU_ADDU;
        dec_bsel = 1'b0;
        dec_ext  = EXT_ZERO;
        case (OP)
            OP_R: begin
                case (Funct)
                    FN_ADDU: begin cls = C_RALU; dec_alu = ALU_ADDU; end
                    FN_SUBU: begin cls = C_RALU; dec_alu = ALU_SUBU; end
                    FN_AND:  begin cls = C_RALU; dec_alu = ALU_AND;  end
                    FN_OR:   begin cls = C_RALU; dec_alu = ALU_OR;   end
                    FN_NOR:  begin cls = C_RALU; dec_alu = ALU_NOR;  end
                    FN_SLT:  begin cls = C_RALU; dec_alu = ALU_SLT;  end
                    FN_SRL:  begin cls = C_RALU; dec_alu = ALU_SRL;  end
                    FN_JR:   cls = C_JR;
                    default: cls = C_ILL;
                endcase
            end
            OP_ADDI: begin
                cls = C_IALU; dec_alu = ALU_ADDU; dec_bsel = 1'b1; dec_ext = EXT_SIGN;
            end
            OP_SLTI: begin
                cls = C_IALU; dec_alu = ALU_SLT; dec_bsel = 1'b1; dec_ext = EXT_SIGN;
            end
            OP_ANDI: begin
                cls = C_IALU; dec_alu = ALU_AND; dec_bsel = 1'b1; dec_ext = EXT_ZERO;
            end
            OP_ORI: begin
                cls = C_IALU; dec_alu = ALU_OR; dec_bsel = 1'b1; dec_ext = EXT_ZERO;
            end
            OP_LUI: begin
                cls = C_IALU; dec_alu = ALU_OR; dec_bsel = 1'b1; dec_ext = EXT_LUI;
            end
            OP_LW: begin
                cls = C_LW; dec_alu = ALU_ADDU; dec_bsel = 1'b1; dec_ext = EXT_SIGN;
            end
            OP_SW: begin
                cls = C_SW; dec_alu = ALU_ADDU; dec_bsel = 1'b1; dec_ext = EXT_SIGN;
            end
            OP_BEQ: begin
                cls = C_BEQ; dec_alu = ALU_SUBU; dec_ext = EXT_SIGN;
            end
            OP_BNE: begin
                cls = C_BNE; dec_alu = ALU_SUBU; dec_ext = EXT_SIGN;
            end
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            default: cls = C_ILL;
        endcase
    end

    // State register with asynchronous return to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control; Done marks the last cycle of a legal instruction.
    always_comb begin
        state_d = FETCH;
        pcwr    = 1'b0;
        irwr    = 1'b0;
        rfwr    = 1'b0;
        dmwr    = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        npc     = NPC_PC4;
        wdsel   = WD_ALU;
        gprsel  = GPR_RT;
        case (state_q)
            FETCH: begin
                irwr    = 1'b1;
                pcwr    = 1'b1;
                state_d = DCD;
            end
            DCD: begin
                case (cls)
                    C_J: begin
                        pcwr = 1'b1;
                        npc  = NPC_J;
                        done = 1'b1;
                    end
                    C_JAL: begin
                        // PC already holds PC+4 here, so it is the link value.
                        pcwr   = 1'b1;
                        npc    = NPC_J;
                        rfwr   = 1'b1;
                        gprsel = GPR_31;
                        wdsel  = WD_PC;
                        done   = 1'b1;
                    end
                    C_ILL:   illegal = 1'b1;
                    default: state_d = EXE;
                endcase
            end
            EXE: begin
                case (cls)
                    C_JR: begin
                        pcwr = 1'b1;
                        npc  = NPC_RS;
                        done = 1'b1;
                    end
                    C_BEQ: begin
                        npc  = NPC_BR;
                        pcwr = Zero;
                        done = 1'b1;
                    end
                    C_BNE: begin
                        npc  = NPC_BR;
                        pcwr = ~Zero;
                        done = 1'b1;
                    end
                    C_LW, C_SW:     state_d = MA;
                    C_RALU, C_IALU: state_d = WB;
                    default:        state_d = FETCH;
                endcase
            end
            MA: begin
                case (cls)
                    C_SW: begin
                        dmwr = 1'b1;
                        done = 1'b1;
                    end
                    C_LW:    state_d = MWB;
                    default: state_d = FETCH;
                endcase
            end
            WB: begin
                rfwr   = 1'b1;
                wdsel  = WD_ALU;
                gprsel = (cls == C_RALU) ? GPR_RD : GPR_RT;
                done   = 1'b1;
            end
            MWB: begin
                rfwr   = 1'b1;
                wdsel  = WD_MDR;
                gprsel = GPR_RT;
                done   = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Output drive: enables and pulses are squashed combinationally while in reset.
    always_comb begin
        PCWr    = pcwr    & rst_n;
        IRWr    = irwr    & rst_n;
        RFWr    = rfwr    & rst_n;
        DMWr    = dmwr    & rst_n;
        Done    = done    & rst_n;
        Illegal = illegal & rst_n;
        NPCOp   = npc;
        WDSel   = wdsel;
        GPRSel  = gprsel;
        State   = state_q;
        if (state_q == FETCH) begin
            ALUOp = '0;
            BSel  = 1'b0;
            EXTOp = '0;
        end else begin
            ALUOp = dec_alu;
            BSel  = dec_bsel;
            EXTOp = dec_ext;
        end
    end

endmodule
